min_packet_arbiter: RTL
=======================

Name: min_packet_arbiter

Overview:
- Shares one MIN packet framer (the min_transmit_fsm instance feeding the transmit FIFO/UART) between N_REQ packet sources, e.g. the I/Q CIC channels and a status source.
- Latches each source's ID and payload at request time and arbitrates round-robin.
- Launches one framer start pulse per packet, then holds until the framer's busy/istx signal completes.
- Reports overruns (request lost to a newer one) and framer-start timeouts.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- N_DATA_BYTE, 4, payload bytes per packet; must match the framer.
- TIMEOUT_CYCLES, 16, cycles to wait in WAIT_BUSY for i_busy to rise before abort.

Ports:
- i_clk  in  1  single clock (sclk domain).
- i_rst  in  1  asynchronous, active-high reset.
- i_en  in  1  enables new grants; an in-flight packet always completes.
- i_req  in  N_REQ  per-source single-cycle request pulse.
- i_id  in  8*N_REQ  packet ID per source; source k uses bits [8k+7:8k].
- i_data  in  8*N_DATA_BYTE*N_REQ  payload per source; slice k, MSB first.
- i_busy  in  1  framer busy (istx) from the framer.
- i_clr  in  1  clears o_overrun and o_timeout.
- o_start  out  1  one-cycle start pulse to the framer's i_en.
- o_id  out  8  registered ID of the granted packet.
- o_data  out  8*N_DATA_BYTE  registered payload of the granted packet.
- o_grant  out  N_REQ  one-hot; the source currently owning the framer.
- o_pending  out  N_REQ  latched, not-yet-served requests.
- o_overrun  out  N_REQ  sticky; a pending request was overwritten.
- o_timeout  out  1  sticky; the framer never went busy after a start.
- o_idle  out  1  high in IDLE.

Behaviour:
- Reset (async, i_rst=1): state IDLE, o_start=0, o_id=0, o_data=0, o_grant=0, o_pending=0, o_overrun=0, o_timeout=0, o_idle=1, RR pointer=0, timeout counter=0, snapshots=0.
  - Reset mid-packet aborts arbitration immediately. The framer is not reset by this block.
- Request capture, every edge, independent of i_en and state:
  - i_req[k]=1 sets pending[k] and copies slice k of i_id/i_data into snapshot k.
  - If pending[k] was already 1 and is not being granted this edge, set overrun[k]; the newest snapshot wins.
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Condition to grant: i_en=1 and pending nonzero.
  - Select the first set pending bit searching from the RR pointer upward, with wrap.
  - Register o_id/o_data from that snapshot, set o_grant one-hot, o_start=1, clear pending[sel], set RR pointer = (sel+1) mod N_REQ, go to START.
  - Latency: i_req sampled at edge E0 -> o_start high after E1 -> low after E2.
- START: o_start=0, timeout counter=0, go to WAIT_BUSY.
- WAIT_BUSY:
  - i_busy=1: go to WAIT_DONE.
  - Otherwise increment the counter; on reaching TIMEOUT_CYCLES, set o_timeout, clear o_grant, go to IDLE.
- WAIT_DONE: i_busy=0 clears o_grant and goes to IDLE. The next grant is possible on the following edge.
- o_id/o_data are held stable from grant until the next grant.
- Request to source k on the same edge k is granted:
  - pending[k] stays 1 with the new snapshot.
  - No overrun is flagged.
  - The granted packet carries the old snapshot.
- i_en=0: no new grants; pending still accumulates; an in-flight packet runs to WAIT_DONE exit.
- i_clr: clears o_overrun/o_timeout. A simultaneous set event wins (the bit stays 1).
- o_idle = (state==IDLE).

Test Plan:
- Single request: reset; i_req=01, i_id[7:0]=0x01, data=0xDEADBEEF -> o_start pulse exactly 2 edges later with o_id=0x01, o_data=0xDEADBEEF, o_grant=01; busy high 5 cycles then low -> o_grant=00, o_idle=1.
- Round-robin fairness: i_req=11 simultaneously, busy model 3 cycles each, repeated 4 times -> grant order 0,1,0,1,… and no overrun.
- Overrun: two pulses on source 1 (data 0x11111111 then 0x22222222) while source 0 is in flight -> overrun=10; source 1 packet carries 0x22222222; i_clr -> overrun=00.
- Timeout: i_busy held 0 after start, TIMEOUT_CYCLES=16 -> o_timeout=1 after 16 WAIT_BUSY cycles, state IDLE, pending source served next.
- Enable and reset: i_en=0 with requests -> no o_start, o_pending=11; raise i_en -> grants resume. Assert i_rst during WAIT_DONE -> all outputs return to reset values asynchronously.
- Same-edge request/grant: pulse source 0 on its grant edge -> old payload sent, pending[0]=1 afterwards, overrun[0]=0, second packet sent with new payload.

Source files
------------

// File: rtl/min_packet_arbiter.sv
// min_packet_arbiter: round-robin sharing of one MIN packet framer between N_REQ sources,
// with per-source request snapshots, overrun flags and a framer-start timeout.
module min_packet_arbiter #(
  parameter int N_REQ          = 2,
  parameter int N_DATA_BYTE    = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_en,
  input  logic [N_REQ-1:0]                 i_req,
  input  logic [8*N_REQ-1:0]               i_id,
  input  logic [8*N_DATA_BYTE*N_REQ-1:0]   i_data,
  input  logic                             i_busy,
  input  logic                             i_clr,
  output logic                             o_start,
  output logic [7:0]                       o_id,
  output logic [8*N_DATA_BYTE-1:0]         o_data,
  output logic [N_REQ-1:0]                 o_grant,
  output logic [N_REQ-1:0]                 o_pending,
  output logic [N_REQ-1:0]                 o_overrun,
  output logic                             o_timeout,
  output logic                             o_idle
);
  localparam int DW = 8 * N_DATA_BYTE;
  localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t            state_q, state_d;
  logic              start_q, start_d;
  logic [7:0]        id_q, id_d;
  logic [DW-1:0]     data_q, data_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  pending_q, pending_d;
  logic [N_REQ-1:0]  overrun_q, overrun_d;
  logic              timeout_q, timeout_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0]        snap_id_q [N_REQ];
  logic [7:0]        snap_id_d [N_REQ];
  logic [DW-1:0]     snap_data_q [N_REQ];
  logic [DW-1:0]     snap_data_d [N_REQ];

  logic [N_REQ-1:0]  rot;
  logic [PW-1:0]     off, sel;
  logic [PW:0]       sum;
  logic              go;

  // Rotate pending so the RR pointer sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    rot = N_REQ'({pending_q, pending_q} >> ptr_q);
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) if (rot[i]) off = PW'(i);
    sum = {1'b0, ptr_q} + {1'b0, off};
    sel = sum >= (PW + 1)'(N_REQ) ? PW'(sum - (PW + 1)'(N_REQ)) : PW'(sum);
    go  = state_q == IDLE && i_en && |pending_q;
  end

  always_comb begin
    state_d     = state_q;
    start_d     = go;
    id_d        = id_q;
    data_d      = data_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    pending_d   = pending_q;
    overrun_d   = i_clr ? '0 : overrun_q;
    timeout_d   = i_clr ? 1'b0 : timeout_q;
    snap_id_d   = snap_id_q;
    snap_data_d = snap_data_q;
    case (state_q)
      IDLE: if (go) begin
        state_d        = START;
        id_d           = snap_id_q[sel];
        data_d         = snap_data_q[sel];
        grant_d        = '0;
        grant_d[sel]   = 1'b1;
        pending_d[sel] = 1'b0;
        ptr_d          = sel == PW'(N_REQ - 1) ? '0 : sel + 1'b1;
      end
      START: begin
        state_d = WAIT_BUSY;
        cnt_d   = '0;
      end
      WAIT_BUSY: if (i_busy) state_d = WAIT_DONE;
      else begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == CW'(TIMEOUT_CYCLES)) begin
          timeout_d = 1'b1;
          grant_d   = '0;
          state_d   = IDLE;
        end
      end
      default: if (!i_busy) begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
    // A request landing on its own grant edge re-arms pending instead of overrunning.
    for (int k = 0; k < N_REQ; k++) if (i_req[k]) begin
      if (pending_q[k] && !(go && sel == PW'(k))) overrun_d[k] = 1'b1;
      pending_d[k]   = 1'b1;
      snap_id_d[k]   = i_id[8*k +: 8];
      snap_data_d[k] = i_data[DW*k +: DW];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      id_q      <= '0;
      data_q    <= '0;
      grant_q   <= '0;
      pending_q <= '0;
      overrun_q <= '0;
      timeout_q <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      for (int k = 0; k < N_REQ; k++) begin
        snap_id_q[k]   <= '0;
        snap_data_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      id_q        <= id_d;
      data_q      <= data_d;
      grant_q     <= grant_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      snap_id_q   <= snap_id_d;
      snap_data_q <= snap_data_d;
    end

  assign o_start   = start_q;
  assign o_id      = id_q;
  assign o_data    = data_q;
  assign o_grant   = grant_q;
  assign o_pending = pending_q;
  assign o_overrun = overrun_q;
  assign o_timeout = timeout_q;
  assign o_idle    = state_q == IDLE;
endmodule
